// File: rtl/axis_ramp_source.sv
// AXI4-Stream ramp generator: emits num_beats beats of incrementing bytes,
// framed into PKT_LEN-beat packets, behind a start/busy/done control handshake.
module axis_ramp_source #(
   parameter int DATA_WIDTH = 32,
   parameter int PKT_LEN    = 16,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                    aclk,
   input  logic                    areset,
   input  logic                    start,
   input  logic [CNT_WIDTH-1:0]    num_beats,
   input  logic [7:0]              start_value,
   output logic                    busy,
   output logic                    done,
   output logic [DATA_WIDTH-1:0]   m_axis_tdata,
   output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
   output logic                    m_axis_tlast,
   output logic                    m_axis_tvalid,
   input  logic                    m_axis_tready
);

   localparam int                 BYTES     = DATA_WIDTH / 8;
   localparam int                 PKT_W     = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
   localparam logic [PKT_W-1:0]   PKT_END   = PKT_W'((PKT_LEN > 0) ? PKT_LEN - 1 : 0);
   localparam logic [7:0]         BEAT_STEP = 8'(BYTES);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t               state;
   logic [CNT_WIDTH-1:0] beat_cnt;
   logic [CNT_WIDTH-1:0] last_idx;
   logic [PKT_W-1:0]     pkt_cnt;
   logic [7:0]           lane0;

   logic                 accept;
   logic [CNT_WIDTH-1:0] next_beat;
   logic [PKT_W-1:0]     next_pkt;
   logic [7:0]           next_lane0;
   logic                 next_last;
   logic                 first_last;

   // Lane k of a beat whose lane 0 holds base; 8-bit adds give the mod-256 wrap.
   function automatic logic [DATA_WIDTH-1:0] ramp(input logic [7:0] base);
      logic [DATA_WIDTH-1:0] d;
      d = '0;
      for (int k = 0; k < BYTES; k++) d[8*k +: 8] = base + 8'(k);
      return d;
   endfunction

   // NOTE: every signal gets a value on every path through always_comb, so no latch is inferred.
   always_comb begin
      accept     = m_axis_tvalid && m_axis_tready;
      next_beat  = beat_cnt + CNT_WIDTH'(1);
      next_lane0 = lane0 + BEAT_STEP;
      next_pkt   = (pkt_cnt == PKT_END) ? '0 : pkt_cnt + PKT_W'(1);
      next_last  = ((PKT_LEN > 0) && (next_pkt == PKT_END)) || (next_beat == last_idx);
      first_last = (PKT_LEN == 1) || (num_beats == CNT_WIDTH'(1));
   end

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge aclk) begin
      if (areset) begin
         state         <= IDLE;
         busy          <= 1'b0;
         done          <= 1'b0;
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
         m_axis_tdata  <= '0;
         beat_cnt      <= '0;
         last_idx      <= '0;
         pkt_cnt       <= '0;
         lane0         <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  busy <= 1'b1;
                  if (num_beats == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     // last_idx rather than num_beats keeps the compare inside CNT_WIDTH
                     state         <= RUN;
                     m_axis_tvalid <= 1'b1;
                     m_axis_tdata  <= ramp(start_value);
                     m_axis_tlast  <= first_last;
                     lane0         <= start_value;
                     beat_cnt      <= '0;
                     pkt_cnt       <= '0;
                     last_idx      <= num_beats - CNT_WIDTH'(1);
                  end
               end
            end
            RUN: begin
               if (accept) begin
                  if (beat_cnt == last_idx) begin
                     state         <= DONE;
                     done          <= 1'b1;
                     m_axis_tvalid <= 1'b0;
                     m_axis_tdata  <= '0;
                     m_axis_tlast  <= 1'b0;
                  end else begin
                     beat_cnt     <= next_beat;
                     lane0        <= next_lane0;
                     pkt_cnt      <= next_pkt;
                     m_axis_tdata <= ramp(next_lane0);
                     m_axis_tlast <= next_last;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign m_axis_tkeep = {BYTES{m_axis_tvalid}};

endmodule

// File: doc/axis_ramp_source.md
AXIS_RAMP_SOURCE -- requirements
Module: axis_ramp_source

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, stream data width in bits; legal values 8, 16, 32, 64.
REQ-002 SHALL have parameter PKT_LEN, default 16, beats per packet for TLAST framing; 0 = TLAST only on the final beat of a run.
REQ-003 SHALL have parameter CNT_WIDTH, default 16, width of the beat-count input.
REQ-004 aclk  input  1  single clock; all logic on the rising edge.
REQ-005 areset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to begin a run; sampled only in IDLE.
REQ-007 num_beats  input  CNT_WIDTH  beats in the run; sampled with start.
REQ-008 start_value  input  8  value of byte lane 0 in the first beat; sampled with start.
REQ-009 busy  output  1  high from the cycle after an accepted start until done.
REQ-010 done  output  1  one-cycle pulse when the run completes.
REQ-011 m_axis_tdata  output  DATA_WIDTH  ramp data; byte lane k in bits [8k+7:8k].
REQ-012 m_axis_tkeep  output  DATA_WIDTH/8  all ones whenever tvalid is high.
REQ-013 m_axis_tlast  output  1  packet boundary marker.
REQ-014 m_axis_tvalid  output  1  beat valid.
REQ-015 m_axis_tready  input  1  downstream (add-one stage) ready.

Function
REQ-016 SHALL implement states IDLE, RUN and DONE.
REQ-017 IDLE with start=1 and num_beats>0 SHALL move to RUN on the next cycle; start and num_beats SHALL be latched, and B=DATA_WIDTH/8.
REQ-018 IDLE with start=1 and num_beats=0 SHALL move to DONE without emitting any beat.
REQ-019 Beat n (0-based), lane k SHALL equal (start_value + n*B + k) mod 256; 8-bit wrap-around is required.
REQ-020 In RUN, tvalid SHALL be high every cycle; the first beat SHALL be presented in the first RUN cycle (1-cycle start-to-tvalid latency).
REQ-021 A beat SHALL be accepted only when tvalid and tready are both high; the next beat SHALL appear on the following cycle, allowing full throughput of 1 beat/cycle.
REQ-022 While tvalid=1 and tready=0, tdata, tkeep and tlast SHALL be held stable and tvalid SHALL NOT drop.
REQ-023 tlast SHALL be 1 on beat n when (PKT_LEN>0 and (n+1) mod PKT_LEN == 0) or when n == num_beats-1.
REQ-024 Acceptance of beat num_beats-1 SHALL move the FSM to DONE; tvalid SHALL be 0 in the DONE cycle.
REQ-025 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-026 busy SHALL be 1 in RUN and DONE and 0 in IDLE.
REQ-027 start asserted while in RUN or DONE SHALL be ignored and SHALL NOT be queued.
REQ-028 The beat counter SHALL be CNT_WIDTH wide; num_beats = 2^CNT_WIDTH-1 SHALL complete without counter overflow.
REQ-029 When tvalid=0, tdata and tlast SHALL be 0.

Reset
REQ-030 areset=1 SHALL force the IDLE state and set busy=0, done=0, tvalid=0, tlast=0, tdata=0 and all counters to 0 on the next edge.
REQ-031 areset asserted mid-run SHALL abort the run without a done pulse; any beat pending on the bus SHALL be dropped.
REQ-032 areset SHALL take priority over start in the same cycle.

Verification
REQ-033 DATA_WIDTH=32, start_value=0, num_beats=256, PKT_LEN=0, tready=1: tdata sequence 0x03020100, 0x07060504, ... 0xFFFEFDFC; tlast only on beat 255; done 1 cycle after the last beat; 257 cycles from start to done.
REQ-034 start_value=0xFE, num_beats=2: beat0 0x0100FFFE, beat1 0x05040302; tlast on beat1.
REQ-035 PKT_LEN=4, num_beats=10, tready=1: tlast on beats 3, 7 and 9 only.
REQ-036 num_beats=8, tready driven by a random pattern (~50%): exactly 8 handshakes; tdata/tlast stable during every stall; data matches the REQ-019 rule.
REQ-037 num_beats=0: done pulses 1 cycle after start; tvalid never asserts.
REQ-038 areset pulsed after beat 3 of 16: tvalid=0 and busy=0 after the next edge; no done pulse; a new start then runs cleanly from its own start_value.
